// File: rtl/phase_sequencer.sv
// Five-phase timer sequencer: walks enabled phases in ascending order, raising one Ti
// request at a time and advancing on the matching To expiry, with a per-phase watchdog.
module phase_sequencer #(
    parameter logic [4:0]  PHASE_EN = 5'b11111,
    parameter logic [13:0] WD_LIMIT = 14'd16383
) (
    input  logic       S_AXIS_ACLK,
    input  logic       S_AXIS_ARESETN,
    input  logic       start,
    input  logic       abort,
    input  logic       To1,
    input  logic       To2,
    input  logic       To3,
    input  logic       To4,
    input  logic       To5,
    output logic       Ti1,
    output logic       Ti2,
    output logic       Ti3,
    output logic       Ti4,
    output logic       Ti5,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] phase
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  phase_q;
    logic [13:0] wd_q;
    logic [4:0]  ti_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [4:0]  to_vec;
    logic [4:0]  above_mask;
    logic [2:0]  first_phase;
    logic [2:0]  next_phase;
    logic        to_hit;

    assign to_vec = {To5, To4, To3, To2, To1};

    // Enabled phases strictly above the one currently held in phase_q.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_above
            assign above_mask[gi] = PHASE_EN[gi] && (3'(gi + 1) > phase_q);
        end
    endgenerate

    // Lowest set bit wins: iterate downwards so the last match is the lowest phase.
    always_comb begin
        first_phase = 3'd0;
        next_phase  = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (PHASE_EN[i]) begin
                first_phase = 3'(i + 1);
            end
            if (above_mask[i]) begin
                next_phase = 3'(i + 1);
            end
        end
    end

    // ti_q is one-hot on the running phase only, so this picks To_k of the active phase.
    assign to_hit = |(to_vec & ti_q);

    function automatic logic [4:0] phase_onehot(input logic [2:0] p);
        logic [4:0] oh;
        oh = 5'b00000;
        case (p)
            3'd1:    oh = 5'b00001;
            3'd2:    oh = 5'b00010;
            3'd3:    oh = 5'b00100;
            3'd4:    oh = 5'b01000;
            3'd5:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q <= IDLE;
            phase_q <= 3'd0;
            wd_q    <= 14'd0;
            ti_q    <= 5'b00000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        wd_q   <= 14'd0;
                        if (first_phase != 3'd0) begin
                            state_q <= RUN;
                            phase_q <= first_phase;
                            ti_q    <= phase_onehot(first_phase);
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        phase_q <= 3'd0;
                        ti_q    <= 5'b00000;
                        busy_q  <= 1'b0;
                        wd_q    <= 14'd0;
                    end else if (to_hit) begin
                        ti_q <= 5'b00000;
                        wd_q <= 14'd0;
                        if (next_phase != 3'd0) begin
                            state_q <= GAP;
                        end else begin
                            state_q <= FIN;
                            phase_q <= 3'd0;
                            done_q  <= 1'b1;
                        end
                    end else if (wd_q == WD_LIMIT) begin
                        state_q <= IDLE;
                        phase_q <= 3'd0;
                        ti_q    <= 5'b00000;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        wd_q    <= 14'd0;
                    end else begin
                        wd_q <= 14'(wd_q + 14'd1);
                    end
                end
                GAP: begin
                    if (abort) begin
                        state_q <= IDLE;
                        phase_q <= 3'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RUN;
                        phase_q <= next_phase;
                        ti_q    <= phase_onehot(next_phase);
                        wd_q    <= 14'd0;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    phase_q <= 3'd0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    phase_q <= 3'd0;
                    ti_q    <= 5'b00000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Ti1   = ti_q[0];
    assign Ti2   = ti_q[1];
    assign Ti3   = ti_q[2];
    assign Ti4   = ti_q[3];
    assign Ti5   = ti_q[4];
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: four instances (default, sparse mask, short
// watchdog, empty mask) each driven by a simple delay-timer model.
module tb_phase_sequencer;

    logic clk;
    logic rst_n;
    logic [3:0]      start_v;
    logic [3:0]      abort_v;
    logic [3:0][4:0] to_v;
    wire  [3:0][4:0] ti_v;
    wire  [3:0]      busy_v;
    wire  [3:0]      done_v;
    wire  [3:0]      err_v;
    wire  [3:0][2:0] phase_v;

    // Timer model: To_k rises once Ti_k has been high for thr+1 cycles; tie_hi forces To high.
    int unsigned     thr [4][5];
    int unsigned     cnt [4][5];
    logic [3:0][4:0] tie_hi;

    // Monitor state
    int          run_len   [4][5];
    int          last_len  [4][5];
    int          done_cnt  [4];
    int          gap_cnt   [4];
    int          onehot_bad[4];
    int          phase_bad [4];
    logic [4:0]  ti_ever   [4];
    logic [11:0] plog      [4];
    logic [2:0]  last_ph   [4];

    int n_tests;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    phase_sequencer u_dflt (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .To1(to_v[0][0]), .To2(to_v[0][1]), .To3(to_v[0][2]), .To4(to_v[0][3]), .To5(to_v[0][4]),
        .Ti1(ti_v[0][0]), .Ti2(ti_v[0][1]), .Ti3(ti_v[0][2]), .Ti4(ti_v[0][3]), .Ti5(ti_v[0][4]),
        .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .phase(phase_v[0])
    );

    phase_sequencer #(.PHASE_EN(5'b10001)) u_mask (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .To1(to_v[1][0]), .To2(to_v[1][1]), .To3(to_v[1][2]), .To4(to_v[1][3]), .To5(to_v[1][4]),
        .Ti1(ti_v[1][0]), .Ti2(ti_v[1][1]), .Ti3(ti_v[1][2]), .Ti4(ti_v[1][3]), .Ti5(ti_v[1][4]),
        .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .phase(phase_v[1])
    );

    phase_sequencer #(.WD_LIMIT(14'd100)) u_wd (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .start(start_v[2]), .abort(abort_v[2]),
        .To1(to_v[2][0]), .To2(to_v[2][1]), .To3(to_v[2][2]), .To4(to_v[2][3]), .To5(to_v[2][4]),
        .Ti1(ti_v[2][0]), .Ti2(ti_v[2][1]), .Ti3(ti_v[2][2]), .Ti4(ti_v[2][3]), .Ti5(ti_v[2][4]),
        .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]), .phase(phase_v[2])
    );

    phase_sequencer #(.PHASE_EN(5'b00000)) u_zero (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .start(start_v[3]), .abort(abort_v[3]),
        .To1(to_v[3][0]), .To2(to_v[3][1]), .To3(to_v[3][2]), .To4(to_v[3][3]), .To5(to_v[3][4]),
        .Ti1(ti_v[3][0]), .Ti2(ti_v[3][1]), .Ti3(ti_v[3][2]), .Ti4(ti_v[3][3]), .Ti5(ti_v[3][4]),
        .busy(busy_v[3]), .done(done_v[3]), .err(err_v[3]), .phase(phase_v[3])
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 5; j++)
                    cnt[i][j] <= 0;
        end else begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 5; j++)
                    cnt[i][j] <= ti_v[i][j] ? cnt[i][j] + 1 : 0;
        end
    end

    always_comb begin
        to_v = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 5; j++)
                to_v[i][j] = tie_hi[i][j] | (ti_v[i][j] && (cnt[i][j] >= thr[i][j]));
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                done_cnt[i]   <= 0;
                gap_cnt[i]    <= 0;
                onehot_bad[i] <= 0;
                phase_bad[i]  <= 0;
                ti_ever[i]    <= 5'b00000;
                plog[i]       <= 12'd0;
                last_ph[i]    <= 3'd0;
                for (int j = 0; j < 5; j++) begin
                    run_len[i][j]  <= 0;
                    last_len[i][j] <= 0;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if ($countones(ti_v[i]) > 1) onehot_bad[i] <= onehot_bad[i] + 1;
                if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
                if (busy_v[i] && ti_v[i] == 5'b00000 && !done_v[i]) gap_cnt[i] <= gap_cnt[i] + 1;
                ti_ever[i] <= ti_ever[i] | ti_v[i];
                if (phase_v[i] != 3'd0 && phase_v[i] != last_ph[i])
                    plog[i] <= {plog[i][8:0], phase_v[i]};
                last_ph[i] <= phase_v[i];
                for (int j = 0; j < 5; j++) begin
                    if (ti_v[i][j]) begin
                        run_len[i][j] <= run_len[i][j] + 1;
                        if (phase_v[i] != 3'(j + 1)) phase_bad[i] <= phase_bad[i] + 1;
                    end else if (run_len[i][j] != 0) begin
                        last_len[i][j] <= run_len[i][j];
                        run_len[i][j]  <= 0;
                    end
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    task automatic pulse_start(input int idx);
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
    endtask

    int n;
    int d0;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        start_v = '0;
        abort_v = '0;
        tie_hi  = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 5; j++)
                thr[i][j] = 5;
        thr[0][0] = 193; thr[0][1] = 62; thr[0][3] = 192; thr[0][4] = 7998;
        tie_hi[0] = 5'b00100;
        thr[2][0] = 3;   thr[2][1] = 1000000;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ti",    32'(ti_v),    32'd0);
        check_eq("rst_busy",  32'(busy_v),  32'd0);
        check_eq("rst_done",  32'(done_v),  32'd0);
        check_eq("rst_err",   32'(err_v),   32'd0);
        check_eq("rst_phase", 32'(phase_v), 32'd0);
        rst_n = 1'b1;

        // Full default sequence, with a stray start during phase 2
        pulse_start(0);
        check_eq("a_first_start_busy", 32'(busy_v[0]), 32'd1);
        check_eq("a_first_phase",      32'(phase_v[0]), 32'd1);
        n = 1;
        while (!done_v[0] && n < 9000) begin
            start_v[0] = (n == 200);
            @(negedge clk);
            n++;
        end
        start_v[0] = 1'b0;
        check_eq("a_cycles_to_done", 32'(n), 32'd8455);
        @(negedge clk);
        #1;
        check_eq("a_ti1_len", 32'(last_len[0][0]), 32'd194);
        check_eq("a_ti2_len", 32'(last_len[0][1]), 32'd63);
        check_eq("a_ti3_len", 32'(last_len[0][2]), 32'd1);
        check_eq("a_ti4_len", 32'(last_len[0][3]), 32'd193);
        check_eq("a_ti5_len", 32'(last_len[0][4]), 32'd7999);
        check_eq("a_gaps",    32'(gap_cnt[0]),    32'd4);
        check_eq("a_done_cnt", 32'(done_cnt[0]),  32'd1);
        check_eq("a_busy_after", 32'(busy_v[0]),  32'd0);
        check_eq("a_onehot_bad", 32'(onehot_bad[0]), 32'd0);
        check_eq("a_phase_bad",  32'(phase_bad[0]),  32'd0);

        // Sparse mask: phase 1 then phase 5
        pulse_start(1);
        n = 1;
        while (!done_v[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("b_cycles_to_done", 32'(n), 32'd14);
        @(negedge clk);
        #1;
        check_eq("b_ti_ever",  32'(ti_ever[1]),     32'b10001);
        check_eq("b_ti1_len",  32'(last_len[1][0]), 32'd6);
        check_eq("b_ti5_len",  32'(last_len[1][4]), 32'd6);
        check_eq("b_gaps",     32'(gap_cnt[1]),     32'd1);
        check_eq("b_phase_seq", 32'(plog[1]),       32'd13);
        check_eq("b_done_cnt", 32'(done_cnt[1]),    32'd1);

        // Watchdog timeout in phase 2
        pulse_start(2);
        n = 1;
        while (busy_v[2] && n < 400) begin
            @(negedge clk);
            n++;
        end
        #1;
        check_eq("c_cycles_to_idle", 32'(n), 32'd107);
        check_eq("c_ti1_len",  32'(last_len[2][0]), 32'd4);
        check_eq("c_ti2_len",  32'(last_len[2][1]), 32'd101);
        check_eq("c_err",      32'(err_v[2]),       32'd1);
        check_eq("c_ti_low",   32'(ti_v[2]),        32'd0);
        check_eq("c_done_cnt", 32'(done_cnt[2]),    32'd0);
        @(negedge clk);
        start_v[2] = 1'b1;
        abort_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        abort_v[2] = 1'b0;
        check_eq("c_abort_blocks_start", 32'(busy_v[2]), 32'd0);
        check_eq("c_err_still_set",      32'(err_v[2]),  32'd1);
        pulse_start(2);
        check_eq("c_restart_clears_err", 32'(err_v[2]),  32'd0);
        check_eq("c_restart_busy",       32'(busy_v[2]), 32'd1);
        abort_v[2] = 1'b1;
        @(negedge clk);
        abort_v[2] = 1'b0;
        check_eq("c_abort_idle", 32'(busy_v[2]), 32'd0);

        // Abort in cycle 50 of phase 4
        #1;
        d0 = done_cnt[0];
        pulse_start(0);
        n = 1;
        while (n < 311) begin
            @(negedge clk);
            n++;
        end
        check_eq("d_ti4_before_abort", 32'(ti_v[0]), 32'b01000);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        #1;
        check_eq("d_ti_low",   32'(ti_v[0]),         32'd0);
        check_eq("d_busy",     32'(busy_v[0]),       32'd0);
        check_eq("d_ti4_len",  32'(last_len[0][3]),  32'd50);
        check_eq("d_err",      32'(err_v[0]),        32'd0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("d_no_done",  32'(done_cnt[0] - d0), 32'd0);

        // Empty mask: straight to FIN
        pulse_start(3);
        check_eq("e_done",      32'(done_v[3]), 32'd1);
        check_eq("e_busy_fin",  32'(busy_v[3]), 32'd1);
        @(negedge clk);
        check_eq("e_done_drop", 32'(done_v[3]), 32'd0);
        check_eq("e_busy_drop", 32'(busy_v[3]), 32'd0);
        check_eq("e_ti_ever",   32'(ti_ever[3]), 32'd0);

        // Asynchronous reset during phase 5
        pulse_start(0);
        n = 1;
        while (!ti_v[0][4] && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_eq("f_ti5_start_cycle", 32'(n), 32'd456);
        repeat (10) @(negedge clk);
        check_eq("f_ti5_high", 32'(ti_v[0]), 32'b10000);
        #2 rst_n = 1'b0;
        #1;
        check_eq("f_ti5_async_low", 32'(ti_v[0][4]), 32'd0);
        check_eq("f_busy_async",    32'(busy_v[0]),  32'd0);
        check_eq("f_phase_async",   32'(phase_v[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
